// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad front-end for gencon.
// Drives one column low at a time, synchronizes and debounces the rows,
// and turns each accepted press into a single digit, operator or '=' strobe.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE - 1);

    localparam logic [2:0] OP_SIGN = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE
    } state_t;

    state_t          state, state_next;
    logic [1:0]      col_idx, col_next;
    logic [DW-1:0]   dwell, dwell_next;
    logic [BW-1:0]   deb_cnt, deb_next;
    logic [1:0]      row_idx, row_next;
    logic [3:0]      sync_p0, rs;
    logic [3:0]      kp_next;
    logic            rd_next;
    logic [2:0]      op_next;
    logic            eq_next;

    // Lowest-index low row wins when several keys share a column.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // Digit value for the 3x3 numeric block (rows 0-2, columns 0-2).
    function automatic logic [3:0] digit_of(input logic [1:0] r, input logic [1:0] c);
        return ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    endfunction

    assign col_out = ~(4'b0001 << col_idx);

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            sync_p0 <= 4'b1111;
            rs      <= 4'b1111;
        end else begin
            sync_p0 <= row_in;
            rs      <= sync_p0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= ST_SCAN;
        else       state <= state_next;
    end

    // Column, dwell, debounce and captured-row registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            col_idx <= 2'd0;
            dwell   <= '0;
            deb_cnt <= '0;
            row_idx <= 2'd0;
        end else begin
            col_idx <= col_next;
            dwell   <= dwell_next;
            deb_cnt <= deb_next;
            row_idx <= row_next;
        end
    end

    // Registered gencon-side outputs; strobes last exactly one cycle.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            keypad_input   <= 4'd0;
            read_input     <= 1'b0;
            operator_input <= 3'b000;
            equal_input    <= 1'b0;
        end else begin
            keypad_input   <= kp_next;
            read_input     <= rd_next;
            operator_input <= op_next;
            equal_input    <= eq_next;
        end
    end

    // Next-state, counter and key-decode logic.
    always_comb begin
        state_next = state;
        col_next   = col_idx;
        dwell_next = dwell;
        deb_next   = deb_cnt;
        row_next   = row_idx;
        kp_next    = keypad_input;
        rd_next    = 1'b0;
        op_next    = 3'b000;
        eq_next    = 1'b0;

        case (state)
            ST_SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_next = '0;
                    if (rs != 4'b1111) begin
                        row_next   = lowest_low(rs);
                        deb_next   = '0;
                        state_next = ST_DEBOUNCE;
                    end else begin
                        col_next = col_idx + 2'd1;
                    end
                end else begin
                    dwell_next = dwell + DW'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (rs[row_idx]) begin
                    // Bounce or glitch: give up silently and move on.
                    state_next = ST_SCAN;
                    col_next   = col_idx + 2'd1;
                    dwell_next = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = ST_EMIT;
                end else begin
                    deb_next = deb_cnt + BW'(1);
                end
            end

            ST_EMIT: begin
                if (col_idx == 2'd3) begin
                    case (row_idx)
                        2'd0:    op_next = OP_ADD;
                        2'd1:    op_next = OP_SUB;
                        2'd2:    op_next = OP_MUL;
                        default: op_next = OP_SIGN;
                    endcase
                end else if (row_idx != 2'd3) begin
                    kp_next = digit_of(row_idx, col_idx);
                    rd_next = 1'b1;
                end else begin
                    // Bottom row: '*' is equal, '0' a digit, '#' is silent.
                    case (col_idx)
                        2'd0:    eq_next = 1'b1;
                        2'd1: begin
                            kp_next = 4'd0;
                            rd_next = 1'b1;
                        end
                        default: ;
                    endcase
                end
                deb_next   = '0;
                state_next = ST_RELEASE;
            end

            ST_RELEASE: begin
                if (rs == 4'b1111) begin
                    if (deb_cnt == DEB_LAST) begin
                        state_next = ST_SCAN;
                        col_next   = col_idx + 2'd1;
                        dwell_next = '0;
                        deb_next   = '0;
                    end else begin
                        deb_next = deb_cnt + BW'(1);
                    end
                end else begin
                    deb_next = '0;
                end
            end

            default: state_next = ST_SCAN;
        endcase
    end

endmodule
